// File: rtl/soc_pkg.sv
// Shared types, IO map constants and endian helpers for the SoC bus blocks.
package soc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam int IO_CNT_IDX = 63;

    function automatic logic [31:0] bswap32(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

endpackage

// File: rtl/byte_lane_swap.sv
// Optional byte reversal of a 32-bit word and its matching 4-bit lane mask.
module byte_lane_swap
    import soc_pkg::*;
#(
    parameter bit EN = 1'b1
) (
    input  logic [31:0] data_in,
    input  logic [3:0]  mask_in,
    output logic [31:0] data_out,
    output logic [3:0]  mask_out
);

    assign data_out = EN ? bswap32(data_in) : data_in;
    assign mask_out = EN ? {mask_in[0], mask_in[1], mask_in[2], mask_in[3]} : mask_in;

endmodule

// File: rtl/mmio_bridge.sv
// CPU data-port bridge: memory/IO decode, latency-timed memory reads,
// GPIO output registers and a free-running cycle counter.
//
// state | meaning
// IDLE  | accepting requests; IO reads answer next cycle
// WAIT  | memory read outstanding, countdown running, cpu_busy high
module mmio_bridge
    import soc_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int MEM_LAT = 1,
    parameter int N_GPIO  = 1,
    parameter int SWAP    = 1,
    parameter int IO_BIT  = 22
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [31:0]         cpu_wdata,
    input  logic [3:0]          cpu_wmask,
    input  logic                cpu_rstrb,
    output logic [31:0]         cpu_rdata,
    output logic                cpu_rvalid,
    output logic                cpu_busy,
    output logic                err,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [31:0]         mem_wdata,
    output logic [3:0]          mem_wmask,
    output logic                mem_rstrb,
    input  logic [31:0]         mem_rdata,
    output logic [N_GPIO*8-1:0] gpio_o
);

    localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    state_t              state_q;
    state_t              state_d;
    logic [LAT_W-1:0]    lat_q;
    logic [31:0]         cycle_cnt;
    logic [N_GPIO*8-1:0] gpio_q;
    logic [31:0]         rdata_q;
    logic                rvalid_q;
    logic                err_q;

    logic [31:0]         wr_data_sw;
    logic [3:0]          wr_mask_sw;
    logic [31:0]         rd_data_sw;
    logic [3:0]          unused_rd_mask;
    logic [31:0]         io_rdata;

    logic       is_io;
    logic [5:0] io_idx;
    logic       idle;
    logic       wr_req;
    logic       rd_ok;
    logic       mem_rd;
    logic       io_rd;
    logic       lat_done;

    assign is_io    = cpu_addr[IO_BIT];
    assign io_idx   = cpu_addr[7:2];
    assign idle     = (state_q == IDLE);
    assign wr_req   = |cpu_wmask;
    // A read that coincides with a write is dropped in favour of the write.
    assign rd_ok    = cpu_rstrb & ~wr_req & idle;
    assign mem_rd   = rd_ok & ~is_io;
    assign io_rd    = rd_ok & is_io;
    assign lat_done = (state_q == WAIT) && (lat_q == '0);

    byte_lane_swap #(.EN(SWAP != 0)) u_swap_wr (
        .data_in  (cpu_wdata),
        .mask_in  (cpu_wmask),
        .data_out (wr_data_sw),
        .mask_out (wr_mask_sw)
    );

    byte_lane_swap #(.EN(SWAP != 0)) u_swap_rd (
        .data_in  (mem_rdata),
        .mask_in  (4'b0000),
        .data_out (rd_data_sw),
        .mask_out (unused_rd_mask)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (mem_rd) state_d = WAIT;
            WAIT:    if (lat_q == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Countdown starts at MEM_LAT-1 so WAIT spans exactly MEM_LAT cycles.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            if (mem_rd) begin
                lat_q <= LAT_W'(MEM_LAT - 1);
            end else if ((state_q == WAIT) && (lat_q != '0)) begin
                lat_q <= lat_q - LAT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cycle_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            gpio_q <= '0;
        end else if (idle && is_io && cpu_wmask[0]) begin
            for (int k = 0; k < N_GPIO; k++) begin
                if (io_idx == 6'(k)) begin
                    gpio_q[k*8 +: 8] <= cpu_wdata[7:0];
                end
            end
        end
    end

    always_comb begin
        io_rdata = '0;
        if (io_idx == 6'(IO_CNT_IDX)) begin
            io_rdata = cycle_cnt;
        end else begin
            for (int k = 0; k < N_GPIO; k++) begin
                if (io_idx == 6'(k)) begin
                    io_rdata = {24'd0, gpio_q[k*8 +: 8]};
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            rvalid_q <= 1'b0;
            if (lat_done) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_data_sw;
            end else if (io_rd) begin
                rvalid_q <= 1'b1;
                rdata_q  <= io_rdata;
            end
            if ((cpu_rstrb && wr_req) || (!idle && (cpu_rstrb || wr_req))) begin
                err_q <= 1'b1;
            end
        end
    end

    assign cpu_rdata  = rdata_q;
    assign cpu_rvalid = rvalid_q;
    assign cpu_busy   = (state_q == WAIT);
    assign err        = err_q;
    assign mem_addr   = cpu_addr;
    assign mem_wdata  = wr_data_sw;
    assign mem_wmask  = (idle && !is_io) ? wr_mask_sw : 4'b0000;
    assign mem_rstrb  = mem_rd;
    assign gpio_o     = gpio_q;

endmodule

// File: tb/tb_mmio_bridge.sv
// Directed bench for mmio_bridge: a swapping 3-cycle-latency instance and a
// pass-through instance share the CPU-side stimulus.
module tb_mmio_bridge;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_wmask;
    logic        cpu_rstrb;
    logic [31:0] mem_rdata;

    logic [31:0] a_rdata, a_maddr, a_mwdata;
    logic        a_rvalid, a_busy, a_err, a_mrstrb;
    logic [3:0]  a_mwmask;
    logic [15:0] a_gpio;

    logic [31:0] b_rdata, b_maddr, b_mwdata;
    logic        b_rvalid, b_busy, b_err, b_mrstrb;
    logic [3:0]  b_mwmask;
    logic [7:0]  b_gpio;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mmio_bridge #(.ADDR_W(32), .MEM_LAT(3), .N_GPIO(2), .SWAP(1), .IO_BIT(22)) dut (
        .clk(clk), .rstn(rstn),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wmask(cpu_wmask), .cpu_rstrb(cpu_rstrb),
        .cpu_rdata(a_rdata), .cpu_rvalid(a_rvalid), .cpu_busy(a_busy), .err(a_err),
        .mem_addr(a_maddr), .mem_wdata(a_mwdata), .mem_wmask(a_mwmask), .mem_rstrb(a_mrstrb),
        .mem_rdata(mem_rdata), .gpio_o(a_gpio)
    );

    mmio_bridge #(.ADDR_W(32), .MEM_LAT(1), .N_GPIO(1), .SWAP(0), .IO_BIT(22)) dut_ns (
        .clk(clk), .rstn(rstn),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wmask(cpu_wmask), .cpu_rstrb(cpu_rstrb),
        .cpu_rdata(b_rdata), .cpu_rvalid(b_rvalid), .cpu_busy(b_busy), .err(b_err),
        .mem_addr(b_maddr), .mem_wdata(b_mwdata), .mem_wmask(b_mwmask), .mem_rstrb(b_mrstrb),
        .mem_rdata(mem_rdata), .gpio_o(b_gpio)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic        rstrb;
        logic [3:0]  a_mask;
        logic [31:0] a_wdata;
        logic        exp_rstrb;
        logic [3:0]  b_mask;
        logic [31:0] b_wdata;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        cpu_addr  = 32'h0;
        cpu_wdata = 32'h0;
        cpu_wmask = 4'b0000;
        cpu_rstrb = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;

        vecs[0] = '{32'h0000_0100, 32'h1122_3344, 4'b0011, 1'b0, 4'b1100, 32'h4433_2211, 1'b0, 4'b0011, 32'h1122_3344};
        vecs[1] = '{32'h0040_0080, 32'h1122_3344, 4'b0011, 1'b0, 4'b0000, 32'h4433_2211, 1'b0, 4'b0000, 32'h1122_3344};
        vecs[2] = '{32'h0000_0004, 32'hAABB_CCDD, 4'b1000, 1'b0, 4'b0001, 32'hDDCC_BBAA, 1'b0, 4'b1000, 32'hAABB_CCDD};
        vecs[3] = '{32'h0000_0008, 32'h0000_0000, 4'b0000, 1'b1, 4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 32'h0000_0000};
        vecs[4] = '{32'h0040_0008, 32'h0000_0000, 4'b0000, 1'b1, 4'b0000, 32'h0000_0000, 1'b0, 4'b0000, 32'h0000_0000};
        vecs[5] = '{32'h0080_0000, 32'h00FF_00FF, 4'b0101, 1'b0, 4'b1010, 32'hFF00_FF00, 1'b0, 4'b0101, 32'h00FF_00FF};

        rstn      = 1'b0;
        mem_rdata = 32'hDEAD_BEEF;
        idle_in();
        #2;
        chk("rst_rdata",  a_rdata,  32'h0);
        chk("rst_rvalid", a_rvalid, 1'b0);
        chk("rst_busy",   a_busy,   1'b0);
        chk("rst_err",    a_err,    1'b0);
        chk("rst_gpio",   a_gpio,   16'h0);
        chk("rst_mrstrb", a_mrstrb, 1'b0);
        chk("rst_mwmask", a_mwmask, 4'b0000);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;

        // Counter after 100 cycles out of reset
        repeat (100) @(posedge clk);
        #1;
        cpu_addr  = 32'h0040_00FC;
        cpu_rstrb = 1'b1;
        #1 chk("cnt_no_mrstrb", a_mrstrb, 1'b0);
        step();
        chk("cnt100_rvalid", a_rvalid, 1'b1);
        chk("cnt100_value",  a_rdata,  32'd100);
        chk("cnt100_busy",   a_busy,   1'b0);
        idle_in();

        // Counter wrap, with back-to-back IO reads
        force dut.cycle_cnt = 32'hFFFF_FFFF;
        #1 release dut.cycle_cnt;
        cpu_addr  = 32'h0040_00FC;
        cpu_rstrb = 1'b1;
        step();
        chk("cnt_max", a_rdata, 32'hFFFF_FFFF);
        step();
        chk("cnt_wrap_rvalid", a_rvalid, 1'b1);
        chk("cnt_wrap", a_rdata, 32'h0);
        idle_in();

        // GPIO write and readback
        cpu_addr  = 32'h0040_0004;
        cpu_wdata = 32'h1234_56A5;
        cpu_wmask = 4'b0001;
        #1 chk("gpio_wr_mwmask", a_mwmask, 4'b0000);
        step();
        chk("gpio_after_wr", a_gpio, 16'hA500);
        cpu_wdata = 32'h0;
        cpu_wmask = 4'b0000;
        cpu_rstrb = 1'b1;
        step();
        chk("gpio_rd_rvalid", a_rvalid, 1'b1);
        chk("gpio_rd_data",   a_rdata,  32'h0000_00A5);
        chk("gpio_rd_busy",   a_busy,   1'b0);
        cpu_rstrb = 1'b0;
        cpu_addr  = 32'h0040_0000;
        cpu_wdata = 32'h0000_0077;
        cpu_wmask = 4'b0010;
        step();
        chk("gpio_lane1_ignored", a_gpio, 16'hA500);
        cpu_wmask = 4'b0000;
        cpu_addr  = 32'h0040_0014;
        cpu_rstrb = 1'b1;
        step();
        chk("io_unmapped_rd", a_rdata, 32'h0);
        idle_in();
        step();

        // Combinational decode / swap table
        for (int i = 0; i < 6; i++) begin
            cpu_addr  = vecs[i].addr;
            cpu_wdata = vecs[i].wdata;
            cpu_wmask = vecs[i].wmask;
            cpu_rstrb = vecs[i].rstrb;
            #1;
            chk($sformatf("v%0d_a_wmask", i),  a_mwmask, vecs[i].a_mask);
            chk($sformatf("v%0d_a_wdata", i),  a_mwdata, vecs[i].a_wdata);
            chk($sformatf("v%0d_a_rstrb", i),  a_mrstrb, vecs[i].exp_rstrb);
            chk($sformatf("v%0d_b_wmask", i),  b_mwmask, vecs[i].b_mask);
            chk($sformatf("v%0d_b_wdata", i),  b_mwdata, vecs[i].b_wdata);
            chk($sformatf("v%0d_b_rstrb", i),  b_mrstrb, vecs[i].exp_rstrb);
            chk($sformatf("v%0d_maddr", i),    a_maddr,  vecs[i].addr);
            step();
            idle_in();
            repeat (5) step();
        end
        chk("table_no_err_a", a_err, 1'b0);
        chk("table_no_err_b", b_err, 1'b0);

        // Memory read, MEM_LAT=3, swap on; then a request in the rvalid cycle
        cpu_addr  = 32'h0000_0100;
        cpu_rstrb = 1'b1;
        #1;
        chk("mrd_c0_mrstrb", a_mrstrb, 1'b1);
        chk("mrd_c0_busy",   a_busy,   1'b0);
        step();
        idle_in();
        chk("mrd_c1_busy",   a_busy,   1'b1);
        chk("mrd_c1_rvalid", a_rvalid, 1'b0);
        step();
        chk("mrd_c2_busy",   a_busy,   1'b1);
        step();
        chk("mrd_c3_busy",   a_busy,   1'b1);
        mem_rdata = 32'h1122_3344;
        step();
        mem_rdata = 32'hDEAD_BEEF;
        chk("mrd_c4_busy",   a_busy,   1'b0);
        chk("mrd_c4_rvalid", a_rvalid, 1'b1);
        chk("mrd_c4_rdata",  a_rdata,  32'h4433_2211);
        cpu_addr  = 32'h0000_0104;
        cpu_rstrb = 1'b1;
        #1 chk("mrd_c4_accept", a_mrstrb, 1'b1);
        step();
        chk("mrd_c5_busy", a_busy, 1'b1);
        chk("mrd_c5_rvalid", a_rvalid, 1'b0);
        #1 chk("busy_req_no_mrstrb", a_mrstrb, 1'b0);
        step();
        idle_in();
        chk("busy_req_err", a_err, 1'b1);
        step();
        step();
        chk("mrd2_rvalid", a_rvalid, 1'b1);
        chk("mrd2_rdata",  a_rdata,  32'hEFBE_ADDE);
        step();
        chk("mrd2_single_pulse", a_rvalid, 1'b0);

        // Reset while a memory read is outstanding
        cpu_addr  = 32'h0000_0100;
        cpu_rstrb = 1'b1;
        step();
        idle_in();
        chk("mid_busy", a_busy, 1'b1);
        step();
        rstn = 1'b0;
        #1;
        chk("mid_rst_busy",   a_busy,   1'b0);
        chk("mid_rst_rvalid", a_rvalid, 1'b0);
        chk("mid_rst_err",    a_err,    1'b0);
        chk("mid_rst_rdata",  a_rdata,  32'h0);
        chk("mid_rst_gpio",   a_gpio,   16'h0);
        step();
        rstn = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            step();
            if (a_rvalid) seen = 1'b1;
        end
        chk("mid_rst_no_rvalid", seen, 1'b0);
        chk("mid_rst_idle", a_busy, 1'b0);

        // Simultaneous read and write to memory
        cpu_addr  = 32'h0000_0200;
        cpu_wdata = 32'h0102_0304;
        cpu_wmask = 4'b1111;
        cpu_rstrb = 1'b1;
        #1;
        chk("conf_mwmask", a_mwmask, 4'b1111);
        chk("conf_mwdata", a_mwdata, 32'h0403_0201);
        chk("conf_mrstrb", a_mrstrb, 1'b0);
        step();
        idle_in();
        chk("conf_rvalid", a_rvalid, 1'b0);
        chk("conf_err",    a_err,    1'b1);
        chk("conf_busy",   a_busy,   1'b0);
        step();
        chk("conf_err_sticky", a_err, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
